sn_stream_decoder: RTL and testbench
====================================

SN_STREAM_DECODER -- requirements
Module: sn_stream_decoder

Interface
REQ-001 SHALL have parameter WIN_BASE_LOG2, default 4, meaning log2 of the smallest window; legal range 1..5.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one decode window.
REQ-005 SHALL have port clear  input  1  synchronous abort back to IDLE.
REQ-006 SHALL have port window_sel  input  2  window N = 2^(WIN_BASE_LOG2+window_sel).
REQ-007 SHALL have port bipolar  input  1  0 = unipolar, 1 = bipolar encoding.
REQ-008 SHALL have port sn_in  input  1  stochastic bitstream bit.
REQ-009 SHALL have port sn_valid  input  1  qualifies sn_in; bits with sn_valid=0 are ignored.
REQ-010 SHALL have port busy  output  1  high in ACCUM.
REQ-011 SHALL have port result  output  8  decoded value (unsigned unipolar, two's complement bipolar).
REQ-012 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-013 SHALL have port saturated  output  1  set when the last result was clipped.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: start=1 latches window_sel and bipolar, zeroes bit and ones counters, goes to ACCUM next cycle.
REQ-016 ACCUM: each cycle with sn_valid=1 increments the bit counter and adds sn_in to the ones counter (K); start is ignored.
REQ-017 When the Nth valid bit is accepted, the FSM SHALL enter DONE on the next edge, registering result and pulsing result_valid for exactly that DONE cycle.
REQ-018 DONE lasts one cycle; then IDLE, or ACCUM directly if start=1 during DONE (back-to-back windows, no lost bits after DONE).
REQ-019 Unipolar: result = K * 2^(8-log2 N); K = N gives 256, clipped to 255 with saturated=1.
REQ-020 Bipolar: result = K * 2^(8-log2 N) - 128 as signed 8-bit; K = N gives +128, clipped to +127 with saturated=1; K = 0 gives -128 unclipped.
REQ-021 Counters SHALL be wide enough for K = N at the largest window (9 bits at WIN_BASE_LOG2=5); no wrap-around permitted.
REQ-022 result and saturated SHALL hold their values until the next DONE.
REQ-023 clear=1 in any state SHALL force IDLE next cycle, discard partial counts, leave result/saturated unchanged, suppress result_valid; clear has priority over start and over window completion.
REQ-024 Changes on window_sel/bipolar during ACCUM SHALL have no effect on the current window.

Reset
REQ-025 rst_n=1 SHALL immediately force IDLE, counters 0, busy=0, result=0, result_valid=0, saturated=0.
REQ-026 Reset mid-window SHALL discard the window with no result_valid pulse.

Configuration
REQ-027 With macro SN_DECODER_CONTINUOUS_EN defined, DONE SHALL always go to ACCUM reusing latched config (start needed only from IDLE), so windows repeat until clear or reset.
REQ-028 Without SN_DECODER_CONTINUOUS_EN, behaviour SHALL be exactly REQ-018.

Structure
REQ-029 Package sn_pkg SHALL hold the FSM state enum, WIN_BASE_LOG2 default, result width constant 8, and the bipolar offset 128.
REQ-030 Scaling/offset/saturation SHALL be a combinational sub-module sn_window_scaler (inputs K, window_sel, bipolar; outputs value, sat).

Verification
REQ-031 Unipolar, window_sel=0 (N=16), 12 ones in 16 valid bits -> result=192, saturated=0, one result_valid pulse.
REQ-032 Bipolar, window_sel=1 (N=32), all 32 bits one -> result=127 (0x7F), saturated=1; all zero -> result=0x80, saturated=0.
REQ-033 N=16 with sn_valid toggled every other cycle -> completion after exactly 16 valid bits (32 cycles); invalid bits not counted.
REQ-034 clear asserted at bit 10 of 16 -> IDLE, no pulse, previous result retained; next start decodes fresh window correctly.
REQ-035 rst_n asserted mid-ACCUM -> all outputs 0 asynchronously; start pulsed during DONE -> next window begins with no gap.
REQ-036 With SN_DECODER_CONTINUOUS_EN, single start, N=16, constant sn_in=1 -> result_valid every 17 cycles, result=255, saturated=1.

Source files
------------

// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared types and constants for the stochastic bitstream decoder
//   Holds the decoder FSM state enum, the default smallest-window exponent,
//   the result width and the bipolar offset.
package sn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } sn_state_t;

  localparam int SN_WIN_BASE_LOG2_DEFAULT = 4;
  localparam int SN_RESULT_W              = 8;
  localparam int SN_BIPOLAR_OFFSET        = 128;

endpackage

// File: rtl/sn_window_scaler.sv
// rtl/sn_window_scaler.sv - combinational scale, offset and clip of a ones count
//   k          : ones count for the completed window (K <= N)
//   window_sel : selects N = 2^(WIN_BASE_LOG2 + window_sel)
//   bipolar    : 0 = unsigned result, 1 = two's complement result
//   value      : K * 2^(8 - log2 N), minus 128 when bipolar, clipped
//   sat        : high when value was clipped (only K = N reaches 256)
module sn_window_scaler
  import sn_pkg::*;
#(
  parameter int WIN_BASE_LOG2 = SN_WIN_BASE_LOG2_DEFAULT,
  parameter int CNT_W         = WIN_BASE_LOG2 + 4
) (
  input  logic [CNT_W-1:0]       k,
  input  logic [1:0]             window_sel,
  input  logic                   bipolar,
  output logic [SN_RESULT_W-1:0] value,
  output logic                   sat
);

  localparam int SCALED_W = CNT_W + SN_RESULT_W;

  logic [3:0]          log2_n;
  logic [3:0]          shift;
  logic [SCALED_W-1:0] scaled;

  always_comb begin
    value  = '0;
    sat    = 1'b0;
    log2_n = 4'(WIN_BASE_LOG2) + {2'b00, window_sel};
    // log2 N never exceeds 8 for legal WIN_BASE_LOG2, so the shift is non-negative.
    shift  = 4'(SN_RESULT_W) - log2_n;
    scaled = SCALED_W'(k) << shift;
    if (scaled > SCALED_W'(2 ** SN_RESULT_W - 1)) begin
      sat   = 1'b1;
      value = bipolar ? SN_RESULT_W'(2 ** (SN_RESULT_W - 1) - 1)
                      : SN_RESULT_W'(2 ** SN_RESULT_W - 1);
    end else if (bipolar) begin
      value = scaled[SN_RESULT_W-1:0] - SN_RESULT_W'(SN_BIPOLAR_OFFSET);
    end else begin
      value = scaled[SN_RESULT_W-1:0];
    end
  end

endmodule

// File: rtl/sn_stream_decoder.sv
// rtl/sn_stream_decoder.sv - windowed decoder turning a stochastic bitstream into a value
//   clk          : rising-edge clock
//   rst_n        : asynchronous reset, active high
//   start        : begin one decode window (sampled in IDLE and DONE)
//   clear        : synchronous abort to IDLE, highest priority
//   window_sel   : N = 2^(WIN_BASE_LOG2 + window_sel), latched at start
//   bipolar      : 0 = unipolar, 1 = bipolar, latched at start
//   sn_in        : stream bit, qualified by sn_valid
//   sn_valid     : bit qualifier
//   busy         : high while accumulating
//   result       : last decoded value, held until the next completion
//   result_valid : one-cycle pulse in the DONE cycle
//   saturated    : last result was clipped
//   Macro SN_DECODER_CONTINUOUS_EN: DONE always re-enters ACCUM with the latched config.
module sn_stream_decoder
  import sn_pkg::*;
#(
  parameter int WIN_BASE_LOG2 = SN_WIN_BASE_LOG2_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic [1:0]             window_sel,
  input  logic                   bipolar,
  input  logic                   sn_in,
  input  logic                   sn_valid,
  output logic                   busy,
  output logic [SN_RESULT_W-1:0] result,
  output logic                   result_valid,
  output logic                   saturated
);

  // Largest N is 2^(WIN_BASE_LOG2+3); holding K = N needs one more bit.
  localparam int CNT_W = WIN_BASE_LOG2 + 4;

  sn_state_t             state, state_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next, bit_cnt_inc;
  logic [CNT_W-1:0]      k_cnt, k_cnt_next, k_acc;
  logic [CNT_W-1:0]      n_target;
  logic [3:0]            log2_n;
  logic [1:0]            win_sel_q;
  logic                  bipolar_q;
  logic                  cfg_load;
  logic                  res_load;
  logic [SN_RESULT_W-1:0] scaled_value;
  logic                  scaled_sat;

  assign log2_n      = 4'(WIN_BASE_LOG2) + {2'b00, win_sel_q};
  assign n_target    = CNT_W'(1) << log2_n;
  assign bit_cnt_inc = bit_cnt + CNT_W'(1);
  // The scaler sees the count including the bit accepted this cycle, so the
  // result can be registered on the same edge that enters DONE.
  assign k_acc       = k_cnt + CNT_W'(sn_in);

  sn_window_scaler #(
    .WIN_BASE_LOG2 (WIN_BASE_LOG2),
    .CNT_W         (CNT_W)
  ) u_scaler (
    .k          (k_acc),
    .window_sel (win_sel_q),
    .bipolar    (bipolar_q),
    .value      (scaled_value),
    .sat        (scaled_sat)
  );

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    k_cnt_next   = k_cnt;
    cfg_load     = 1'b0;
    res_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_ACCUM;
          cfg_load     = 1'b1;
          bit_cnt_next = '0;
          k_cnt_next   = '0;
        end
      end
      ST_ACCUM: begin
        if (sn_valid) begin
          bit_cnt_next = bit_cnt_inc;
          k_cnt_next   = k_acc;
          if (bit_cnt_inc == n_target) begin
            state_next = ST_DONE;
            res_load   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        bit_cnt_next = '0;
        k_cnt_next   = '0;
`ifdef SN_DECODER_CONTINUOUS_EN
        state_next   = ST_ACCUM;
`else
        if (start) begin
          state_next = ST_ACCUM;
          cfg_load   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
`endif
      end
      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = '0;
        k_cnt_next   = '0;
      end
    endcase
    // clear overrides start and window completion alike.
    if (clear) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      k_cnt_next   = '0;
      cfg_load     = 1'b0;
      res_load     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      k_cnt     <= '0;
      win_sel_q <= '0;
      bipolar_q <= 1'b0;
      result    <= '0;
      saturated <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      k_cnt   <= k_cnt_next;
      if (cfg_load) begin
        win_sel_q <= window_sel;
        bipolar_q <= bipolar;
      end
      if (res_load) begin
        result    <= scaled_value;
        saturated <= scaled_sat;
      end
    end
  end

  assign busy         = (state == ST_ACCUM);
  assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_sn_stream_decoder.sv
// tb/tb_sn_stream_decoder.sv - self-checking bench for sn_stream_decoder
module tb_sn_stream_decoder;

`ifdef SN_DECODER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] window_sel = 2'd0;
  logic       bipolar = 1'b0;
  logic       sn_in = 1'b0;
  logic       sn_valid = 1'b0;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       saturated;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sn_stream_decoder #(.WIN_BASE_LOG2(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .window_sel   (window_sel),
    .bipolar      (bipolar),
    .sn_in        (sn_in),
    .sn_valid     (sn_valid),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .saturated    (saturated)
  );

  typedef struct {
    logic [1:0] ws;
    logic       bip;
    int         k;
    bit         gap;
    int         exp_res;
    bit         exp_sat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_window(input logic [1:0] ws, input logic bip);
    start      = 1'b1;
    window_sel = ws;
    bipolar    = bip;
    tick();
    start      = 1'b0;
    // Scramble config while accumulating; the latched copy must be used.
    window_sel = ~ws;
    bipolar    = ~bip;
  endtask

  // Feeds ones for the first k valid bits, zeros after, until result_valid.
  task automatic stream(input int k, input bit gap, output int nv, output int ncyc);
    nv   = 0;
    ncyc = 0;
    for (int c = 0; c < 600; c++) begin
      sn_valid = gap ? c[0] : 1'b1;
      sn_in    = sn_valid ? (nv < k) : 1'b1;
      start    = (c == 3);
      tick();
      ncyc++;
      if (sn_valid) nv++;
      if (result_valid) break;
    end
    sn_valid = 1'b0;
    sn_in    = 1'b0;
    start    = 1'b0;
    if (!result_valid) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: got no result_valid after %0d cycles expected a pulse", ncyc);
    end
  endtask

  task automatic feed_ones(input int n);
    for (int i = 0; i < n; i++) begin
      sn_valid = 1'b1;
      sn_in    = 1'b1;
      tick();
    end
    sn_valid = 1'b0;
  endtask

  initial begin
    int nv, ncyc, n, pulses, last_res, last_sat;

    vecs[0]  = '{2'd0, 1'b0, 12,  1'b0, 192, 1'b0};
    vecs[1]  = '{2'd0, 1'b0, 12,  1'b1, 192, 1'b0};
    vecs[2]  = '{2'd0, 1'b0, 16,  1'b0, 255, 1'b1};
    vecs[3]  = '{2'd0, 1'b0, 0,   1'b0, 0,   1'b0};
    vecs[4]  = '{2'd1, 1'b1, 32,  1'b0, 127, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 0,   1'b0, 128, 1'b0};
    vecs[6]  = '{2'd1, 1'b0, 5,   1'b0, 40,  1'b0};
    vecs[7]  = '{2'd0, 1'b1, 8,   1'b0, 0,   1'b0};
    vecs[8]  = '{2'd3, 1'b0, 1,   1'b0, 2,   1'b0};
    vecs[9]  = '{2'd2, 1'b1, 40,  1'b0, 32,  1'b0};
    vecs[10] = '{2'd0, 1'b1, 3,   1'b0, 176, 1'b0};
    vecs[11] = '{2'd2, 1'b0, 63,  1'b0, 252, 1'b0};

    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    chk("reset_result_valid", result_valid, 0);
    chk("reset_saturated", saturated, 0);
    rst_n = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 12; i++) begin
      n = 1 << (4 + vecs[i].ws);
      begin_window(vecs[i].ws, vecs[i].bip);
      chk($sformatf("v%0d_busy", i), busy, 1);
      stream(vecs[i].k, vecs[i].gap, nv, ncyc);
      chk($sformatf("v%0d_valid_bits", i), nv, n);
      chk($sformatf("v%0d_cycles", i), ncyc, vecs[i].gap ? 2 * n : n);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("v%0d_saturated", i), saturated, vecs[i].exp_sat);
      tick();
      chk($sformatf("v%0d_pulse_width", i), result_valid, 0);
      chk($sformatf("v%0d_busy_after", i), busy, CONT ? 1 : 0);
      chk($sformatf("v%0d_result_held", i), result, vecs[i].exp_res);
      if (CONT) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
    end
    last_res = 252;
    last_sat = 0;

    // clear at bit 10 of 16
    begin_window(2'd0, 1'b0);
    feed_ones(10);
    clear    = 1'b1;
    sn_valid = 1'b1;
    sn_in    = 1'b1;
    tick();
    clear    = 1'b0;
    chk("clear_busy", busy, 0);
    chk("clear_result_valid", result_valid, 0);
    chk("clear_result_kept", result, last_res);
    chk("clear_sat_kept", saturated, last_sat);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    sn_valid = 1'b0;
    chk("clear_no_pulse", pulses, 0);
    begin_window(2'd0, 1'b0);
    stream(4, 1'b0, nv, ncyc);
    chk("after_clear_bits", nv, 16);
    chk("after_clear_result", result, 64);
    if (CONT) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    tick();

    // clear on the completing bit wins over completion
    begin_window(2'd0, 1'b0);
    feed_ones(15);
    clear    = 1'b1;
    sn_valid = 1'b1;
    sn_in    = 1'b1;
    tick();
    clear    = 1'b0;
    sn_valid = 1'b0;
    chk("clear_final_result_valid", result_valid, 0);
    chk("clear_final_busy", busy, 0);
    chk("clear_final_result_kept", result, 64);

    // back-to-back windows: start during DONE
    begin_window(2'd0, 1'b0);
    stream(16, 1'b0, nv, ncyc);
    chk("b2b_first_result", result, 255);
    chk("b2b_first_sat", saturated, 1);
    start      = 1'b1;
    window_sel = 2'd0;
    bipolar    = 1'b0;
    tick();
    start      = 1'b0;
    chk("b2b_busy_no_gap", busy, 1);
    stream(8, 1'b0, nv, ncyc);
    chk("b2b_second_bits", nv, 16);
    chk("b2b_second_cycles", ncyc, 16);
    chk("b2b_second_result", result, 128);
    chk("b2b_second_sat", saturated, 0);
    if (CONT) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    tick();

    // asynchronous reset mid-window
    begin_window(2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sn_valid = 1'b1;
      sn_in    = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    #2;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_result_valid", result_valid, 0);
    chk("async_rst_saturated", saturated, 0);
    tick();
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    sn_valid = 1'b0;
    chk("post_rst_no_pulse", pulses, 0);
    chk("post_rst_idle", busy, 0);

`ifdef SN_DECODER_CONTINUOUS_EN
    begin_window(2'd0, 1'b0);
    stream(1000, 1'b0, nv, ncyc);
    chk("cont_first_cycles", ncyc, 16);
    for (int p = 0; p < 3; p++) begin
      stream(1000, 1'b0, nv, ncyc);
      chk($sformatf("cont_period_%0d", p), ncyc, 17);
      chk($sformatf("cont_result_%0d", p), result, 255);
      chk($sformatf("cont_sat_%0d", p), saturated, 1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("cont_clear_idle", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
